// File: rtl/exers_age.sv
// exers_age: age-ordered reservation station for the execute stage.
// Holds renamed ops until both operands are ready, captures operands from
// writeback ports, and issues the oldest routable op to one of two
// single-cycle ALUs or two multi-cycle ALUs each cycle.
module exers_age #(
    parameter int RS_ENTRIES = 32,
    parameter int WB_PORTS   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rename_exers_write,
    input  logic [4:0]                   rename_op,
    input  logic [6:0]                   rename_robid,
    input  logic [5:0]                   rename_rd,
    input  logic                         rename_op1ready,
    input  logic                         rename_op2ready,
    input  logic [31:0]                  rename_op1,
    input  logic [31:0]                  rename_op2,
    output logic                         exers_stall,
    output logic [6:0]                   exers_robid,
    output logic [5:0]                   exers_rd,
    output logic [31:0]                  exers_op1,
    output logic [31:0]                  exers_op2,
    output logic [4:0]                   exers_op,
    output logic                         exers_scalu0_issue,
    output logic                         exers_scalu1_issue,
    output logic                         exers_mcalu0_issue,
    output logic                         exers_mcalu1_issue,
    input  logic                         scalu0_stall,
    input  logic                         scalu1_stall,
    input  logic                         mcalu0_stall,
    input  logic                         mcalu1_stall,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS-1:0]          wb_error,
    input  logic [7*WB_PORTS-1:0]        wb_robid,
    input  logic [6*WB_PORTS-1:0]        wb_rd,
    input  logic [32*WB_PORTS-1:0]       wb_result,
    input  logic                         rob_flush,
    output logic [$clog2(RS_ENTRIES):0]  exers_count
);

    localparam int IW = $clog2(RS_ENTRIES);
    localparam int CW = IW + 1;

    // Entry storage
    logic [RS_ENTRIES-1:0] valid;
    logic [RS_ENTRIES-1:0] op1_rdy;
    logic [RS_ENTRIES-1:0] op2_rdy;
    logic [4:0]            ent_op    [RS_ENTRIES];
    logic [6:0]            ent_robid [RS_ENTRIES];
    logic [5:0]            ent_rd    [RS_ENTRIES];
    logic [31:0]           ent_op1   [RS_ENTRIES];
    logic [31:0]           ent_op2   [RS_ENTRIES];
    // older[i][j] set means entry i was accepted before entry j. A matrix
    // keeps the order total with no sequence counter that could wrap.
    logic [RS_ENTRIES-1:0] older     [RS_ENTRIES];
    logic [CW-1:0]         count;

    // Combinational working signals
    logic [WB_PORTS-1:0]   wb_resolve;
    logic [RS_ENTRIES-1:0] wake1_hit;
    logic [RS_ENTRIES-1:0] wake2_hit;
    logic [31:0]           wake1_val [RS_ENTRIES];
    logic [31:0]           wake2_val [RS_ENTRIES];
    logic                  ins_hit1;
    logic                  ins_hit2;
    logic [31:0]           ins_val1;
    logic [31:0]           ins_val2;
    logic [IW-1:0]         free_idx;
    logic                  accept;
    logic                  sc_ok;
    logic                  mc_ok;
    logic [RS_ENTRIES-1:0] routable;
    logic [RS_ENTRIES-1:0] select;
    logic                  blocked;
    logic [IW-1:0]         issue_idx;
    logic                  issue_fire;
    logic                  issue_mc;
    logic [CW-1:0]         count_next;
    logic                  unused_wb_rd;

    // Search the resolving writeback ports for a tag; the lowest port wins.
    // Returns {hit, result}.
    function automatic logic [32:0] wb_lookup(
        input logic [6:0]               tag,
        input logic [WB_PORTS-1:0]      res,
        input logic [7*WB_PORTS-1:0]    ids,
        input logic [32*WB_PORTS-1:0]   vals
    );
        logic [32:0] r;
        r = {1'b0, 32'h0000_0000};
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (res[p] && (ids[p*7 +: 7] == tag)) begin
                r = {1'b1, vals[p*32 +: 32]};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign exers_count  = count;
    assign exers_stall  = (count == CW'(RS_ENTRIES));
    assign unused_wb_rd = ^wb_rd;

    // Decide which writeback ports carry a usable result this cycle.
    always_comb begin
        wb_resolve = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_resolve[p] = wb_valid[p] & ~wb_error[p] & ~wb_rd[p*6 + 5];
        end
    end

    // Match every stored operand tag and both rename operand tags against the ports.
    always_comb begin
        wake1_hit = '0;
        wake2_hit = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            {wake1_hit[i], wake1_val[i]} = wb_lookup(ent_op1[i][6:0], wb_resolve, wb_robid, wb_result);
            {wake2_hit[i], wake2_val[i]} = wb_lookup(ent_op2[i][6:0], wb_resolve, wb_robid, wb_result);
        end
        {ins_hit1, ins_val1} = wb_lookup(rename_op1[6:0], wb_resolve, wb_robid, wb_result);
        {ins_hit2, ins_val2} = wb_lookup(rename_op2[6:0], wb_resolve, wb_robid, wb_result);
    end

    // Pick the lowest free slot and qualify the insert against the full flag.
    always_comb begin
        free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IW'(i);
            end else begin
                free_idx = free_idx;
            end
        end
        accept = rename_exers_write & ~exers_stall;
    end

    // Find routable candidates and keep only the one no other routable entry predates.
    always_comb begin
        sc_ok    = ~(scalu0_stall & scalu1_stall & mcalu0_stall & mcalu1_stall);
        mc_ok    = ~(mcalu0_stall & mcalu1_stall);
        routable = '0;
        select   = '0;
        blocked  = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            routable[i] = valid[i] & op1_rdy[i] & op2_rdy[i] &
                          ((ent_op[i][4:3] == 2'b11) ? mc_ok : sc_ok);
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (routable[j] && older[j][i]) begin
                    blocked = 1'b1;
                end else begin
                    blocked = blocked;
                end
            end
            select[i] = routable[i] & ~blocked;
        end
    end

    // Encode the one-hot winner and drive its payload and unit strobe.
    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (select[i]) begin
                issue_idx = IW'(i);
            end else begin
                issue_idx = issue_idx;
            end
        end
        issue_fire  = |select;
        exers_op    = ent_op[issue_idx];
        exers_robid = ent_robid[issue_idx];
        exers_rd    = ent_rd[issue_idx];
        exers_op1   = ent_op1[issue_idx];
        exers_op2   = ent_op2[issue_idx];
        issue_mc    = (ent_op[issue_idx][4:3] == 2'b11);

        exers_scalu0_issue = 1'b0;
        exers_scalu1_issue = 1'b0;
        exers_mcalu0_issue = 1'b0;
        exers_mcalu1_issue = 1'b0;
        if (issue_fire) begin
            if (issue_mc) begin
                if (!mcalu0_stall) begin
                    exers_mcalu0_issue = 1'b1;
                end else begin
                    exers_mcalu1_issue = 1'b1;
                end
            end else begin
                if (!scalu0_stall) begin
                    exers_scalu0_issue = 1'b1;
                end else if (!scalu1_stall) begin
                    exers_scalu1_issue = 1'b1;
                end else if (!mcalu0_stall) begin
                    exers_mcalu0_issue = 1'b1;
                end else begin
                    exers_mcalu1_issue = 1'b1;
                end
            end
        end else begin
            exers_scalu0_issue = 1'b0;
        end
    end

    // Occupancy after this cycle's insert and issue.
    always_comb begin
        case ({accept, issue_fire})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Entry state: reset/flush clear, then wakeup, issue invalidate and insert.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            count <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                older[i] <= '0;
            end
        end else if (rob_flush) begin
            valid <= '0;
            count <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (valid[i] && !op1_rdy[i] && wake1_hit[i]) begin
                    op1_rdy[i] <= 1'b1;
                    ent_op1[i] <= wake1_val[i];
                end
                if (valid[i] && !op2_rdy[i] && wake2_hit[i]) begin
                    op2_rdy[i] <= 1'b1;
                    ent_op2[i] <= wake2_val[i];
                end
            end

            // The free slot is never valid, so it cannot collide with the issuing slot.
            if (issue_fire) begin
                valid[issue_idx] <= 1'b0;
            end

            if (accept) begin
                valid[free_idx]     <= 1'b1;
                ent_op[free_idx]    <= rename_op;
                ent_robid[free_idx] <= rename_robid;
                ent_rd[free_idx]    <= rename_rd;
                ent_op1[free_idx]   <= (!rename_op1ready && ins_hit1) ? ins_val1 : rename_op1;
                ent_op2[free_idx]   <= (!rename_op2ready && ins_hit2) ? ins_val2 : rename_op2;
                op1_rdy[free_idx]   <= rename_op1ready | ins_hit1;
                op2_rdy[free_idx]   <= rename_op2ready | ins_hit2;
                // Newcomer is younger than everything currently held.
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    older[j][free_idx] <= (IW'(j) != free_idx);
                end
                older[free_idx] <= '0;
            end

            count <= count_next;
        end
    end

endmodule
